fftshift_stream_ctrl: RTL and testbench

Frame-based controller that sequences an external 8×256 simple dual-port RAM as a ping-pong buffer. It writes incoming sample frames into one RAM half and replays the other half in fftshift order as a continuous output stream. It sits between the FFT output stream and the spectrum post-processing logic, and owns every RAM port.

---
 rtl/fftshift_stream_ctrl.sv | 97 +++++++++
 tb/tb_fftshift_stream_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fftshift_stream_ctrl.sv
// fftshift_stream_ctrl: ping-pong RAM sequencer that replays each buffered frame in fftshift order.
module fftshift_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q
);
  localparam int IW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] NMAX = {1'b1, {IW{1'b0}}};
  localparam logic [ADDR_W-1:0] ONE = 1;
  localparam logic [IW-1:0] IONE = 1;
  localparam logic [0:0] IDLE = 1'b0, READ = 1'b1;
  logic [1:0] full, vld_d, last_d;
  logic [ADDR_W-1:0] len0, len1, wr_len, rd_len, rd_cnt, eff_len, cur_len, bank_len;
  logic [IW-1:0] wr_idx, rd_idx, half;
  logic wr_bank, rd_bank, state, hs, wr_last, rd_last;
  assign eff_len = cfg_len == '0 ? ONE : cfg_len > NMAX ? NMAX : cfg_len;
  // the first beat of a frame must already see its own length (N = 1 ends on it)
  assign cur_len = wr_idx == '0 ? eff_len : wr_len;
  assign s_ready = ~full[wr_bank];
  assign hs = s_valid & s_ready;
  assign wr_last = hs && {1'b0, wr_idx} == cur_len - ONE;
  assign bank_len = rd_bank ? len1 : len0;
  assign half = bank_len == ONE ? '0 : bank_len[IW:1] + {{(IW-1){1'b0}}, bank_len[0]};
  assign rd_last = state == READ && rd_cnt == rd_len - ONE;
  assign ram_rden = state == READ;
  assign ram_rdaddress = {rd_bank, rd_idx};
  assign m_valid = vld_d[1];
  assign m_last = last_d[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      len0 <= '0;
      len1 <= '0;
      wr_len <= '0;
      wr_idx <= '0;
      wr_bank <= 1'b0;
      rd_len <= '0;
      rd_cnt <= '0;
      rd_idx <= '0;
      rd_bank <= 1'b0;
      state <= IDLE;
      ram_wren <= 1'b0;
      ram_wraddress <= '0;
      ram_data <= '0;
      vld_d <= '0;
      last_d <= '0;
      m_data <= '0;
    end else begin
      ram_wren <= hs;
      if (hs) begin
        ram_wraddress <= {wr_bank, wr_idx};
        ram_data <= s_data;
        wr_len <= cur_len;
        wr_idx <= wr_last ? '0 : wr_idx + IONE;
      end
      if (wr_last) begin
        wr_bank <= ~wr_bank;
        if (wr_bank) len1 <= cur_len;
        else len0 <= cur_len;
      end
      full <= (full | (wr_last ? (2'b01 << wr_bank) : 2'b00)) & ~(rd_last ? (2'b01 << rd_bank) : 2'b00);
      if (state == IDLE) begin
        if (full[rd_bank]) begin
          state <= READ;
          rd_len <= bank_len;
          rd_idx <= half;
          rd_cnt <= '0;
        end
      end else begin
        rd_idx <= {1'b0, rd_idx} == rd_len - ONE ? '0 : rd_idx + IONE;
        rd_cnt <= rd_cnt + ONE;
        if (rd_last) begin
          rd_bank <= ~rd_bank;
          state <= IDLE;
        end
      end
      vld_d <= {vld_d[0], ram_rden};
      last_d <= {last_d[0], rd_last};
      m_data <= ram_q;
    end
  end
endmodule

// File: tb/tb_fftshift_stream_ctrl.sv
// tb_fftshift_stream_ctrl: directed frames through the controller with a behavioural 8x256 RAM.
module tb_fftshift_stream_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] cfg_len, s_data, m_data, ram_wraddress, ram_data, ram_rdaddress;
  logic [7:0] ram_q = '0;
  logic s_valid, s_ready, m_valid, m_last, ram_wren, ram_rden;
  logic [7:0] mem [0:255];
  int checks = 0, failures = 0, cyc = 0, hs_cyc = 0, lowcnt = 0;
  logic [7:0] od[$], din[$], exp_d[$];
  logic ol[$];
  int oc[$];

  fftshift_stream_ctrl #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_rdaddress];
  end

  always @(negedge clk) begin
    if (m_valid) begin
      od.push_back(m_data);
      ol.push_back(m_last);
      oc.push_back(cyc);
    end
    if (s_valid && !s_ready) lowcnt <= lowcnt + 1;
  end

  // called at a negedge; returns at the negedge after the accepting edge with s_valid still high
  task automatic send(input logic [7:0] d);
    int w = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!s_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      failures++;
      checks++;
      $display("FAIL send_timeout: s_ready stayed %0b, want 1", s_ready);
    end
    hs_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (din[i]) send(din[i]);
    s_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int w = 0;
    while (od.size() < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_outs();
    od.delete();
    ol.delete();
    oc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    cfg_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_last, ram_wren, ram_rden} !== 5'b10000 ||
        {m_data, ram_wraddress, ram_data, ram_rdaddress} !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: got rdy=%0b mv=%0b ml=%0b we=%0b re=%0b md=%0d wa=%0d wd=%0d ra=%0d, want 1 0 0 0 0 0 0 0 0",
               s_ready, m_valid, m_last, ram_wren, ram_rden, m_data, ram_wraddress, ram_data, ram_rdaddress);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_port();
    clear_outs();
    cfg_len = 8'd1;
    send(8'd42);
    s_valid = 1'b0;
    checks++;
    if ({ram_wren, ram_wraddress, ram_data} !== {1'b1, 8'd0, 8'd42}) begin
      failures++;
      $display("FAIL write_port: got we=%0b wa=%0d wd=%0d, want 1 0 42", ram_wren, ram_wraddress, ram_data);
    end
    @(negedge clk);
    checks++;
    if ({ram_rden, ram_rdaddress, ram_wren} !== {1'b1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL read_port: got re=%0b ra=%0d we=%0b, want 1 0 0", ram_rden, ram_rdaddress, ram_wren);
    end
    wait_outs(1);
    checks++;
    if (od.size() != 1 || od[0] !== 8'd42 || ol[0] !== 1'b1) begin
      failures++;
      $display("FAIL n1_output: got %0d beats first=%0d last=%0b, want 1 beat 42 last 1",
               od.size(), od.size() > 0 ? od[0] : 8'd0, ol.size() > 0 ? ol[0] : 1'b0);
    end
  endtask

  task automatic test_lengths();
    for (int c = 0; c < 5; c++) begin
      din.delete();
      exp_d.delete();
      case (c)
        0: begin cfg_len = 8'd9; exp_d = '{8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5}; end
        1: begin cfg_len = 8'd8; exp_d = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4}; end
        2: begin cfg_len = 8'd2; din = '{8'd10, 8'd20}; exp_d = '{8'd20, 8'd10}; end
        3: begin cfg_len = 8'd0; din = '{8'd7}; exp_d = '{8'd7}; end
        default: begin
          cfg_len = 8'd200;
          for (int k = 0; k < 128; k++) exp_d.push_back(8'(((k + 64) % 128) + 1));
        end
      endcase
      if (din.size() == 0) for (int k = 0; k < exp_d.size(); k++) din.push_back(8'(k + 1));
      clear_outs();
      send_frame();
      wait_outs(exp_d.size());
      checks++;
      if (od.size() != exp_d.size()) begin
        failures++;
        $display("FAIL len_case%0d_count: got %0d beats, want %0d", c, od.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < od.size(); i++) begin
        checks++;
        if (od[i] !== exp_d[i] || ol[i] !== (i == exp_d.size() - 1)) begin
          failures++;
          $display("FAIL len_case%0d_beat%0d: got data=%0d last=%0b, want data=%0d last=%0b",
                   c, i, od[i], ol[i], exp_d[i], i == exp_d.size() - 1);
        end
      end
      if (c == 0 && oc.size() > 0) begin
        checks++;
        if (oc[0] - hs_cyc != 4) begin
          failures++;
          $display("FAIL n9_latency: got %0d cycles, want 4", oc[0] - hs_cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lc0;
    cfg_len = 8'd4;
    din.delete();
    for (int k = 1; k <= 12; k++) din.push_back(8'(k));
    exp_d = '{8'd3, 8'd4, 8'd1, 8'd2, 8'd7, 8'd8, 8'd5, 8'd6, 8'd11, 8'd12, 8'd9, 8'd10};
    clear_outs();
    lc0 = lowcnt;
    send_frame();
    wait_outs(12);
    checks++;
    if (od.size() != 12) begin
      failures++;
      $display("FAIL b2b_count: got %0d beats, want 12", od.size());
    end
    for (int i = 0; i < 12 && i < od.size(); i++) begin
      checks++;
      if (od[i] !== exp_d[i] || ol[i] !== (i % 4 == 3) || (i > 0 && oc[i] - oc[i-1] != (i % 4 == 0 ? 2 : 1))) begin
        failures++;
        $display("FAIL b2b_beat%0d: got data=%0d last=%0b gap=%0d, want data=%0d last=%0b gap=%0d",
                 i, od[i], ol[i], i > 0 ? oc[i] - oc[i-1] : 0, exp_d[i], i % 4 == 3, i % 4 == 0 ? 2 : 1);
      end
    end
    checks++;
    if (lowcnt - lc0 != 1) begin
      failures++;
      $display("FAIL b2b_stall: got s_ready low for %0d cycles, want 1", lowcnt - lc0);
    end
  endtask

  task automatic test_cfg_change();
    cfg_len = 8'd8;
    clear_outs();
    for (int k = 1; k <= 8; k++) begin
      send(8'(k));
      if (k == 3) cfg_len = 8'd3;
    end
    s_valid = 1'b0;
    wait_outs(8);
    exp_d = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4};
    checks++;
    if (od.size() != 8 || od != exp_d || ol[7] !== 1'b1) begin
      failures++;
      $display("FAIL cfg_hold: got %0d beats first=%0d, want 8 beats 5,6,7,8,1,2,3,4",
               od.size(), od.size() > 0 ? od[0] : 8'd0);
    end
    clear_outs();
    din = '{8'd10, 8'd20, 8'd30};
    send_frame();
    wait_outs(3);
    exp_d = '{8'd30, 8'd10, 8'd20};
    checks++;
    if (od.size() != 3 || od != exp_d || ol[2] !== 1'b1 || ol[0] !== 1'b0) begin
      failures++;
      $display("FAIL cfg_next_n3: got %0d beats first=%0d, want 3 beats 30,10,20",
               od.size(), od.size() > 0 ? od[0] : 8'd0);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    cfg_len = 8'd9;
    din.delete();
    for (int k = 1; k <= 9; k++) din.push_back(8'(k));
    send_frame();
    while (!ram_rden && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, m_valid, m_last, ram_wren, ram_rden} !== 5'b10000 ||
        {m_data, ram_wraddress, ram_data, ram_rdaddress} !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: got rdy=%0b mv=%0b ml=%0b we=%0b re=%0b md=%0d wa=%0d wd=%0d ra=%0d, want 1 0 0 0 0 0 0 0 0",
               s_ready, m_valid, m_last, ram_wren, ram_rden, m_data, ram_wraddress, ram_data, ram_rdaddress);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_outs();
    cfg_len = 8'd4;
    din = '{8'd1, 8'd2, 8'd3, 8'd4};
    send_frame();
    wait_outs(4);
    exp_d = '{8'd3, 8'd4, 8'd1, 8'd2};
    checks++;
    if (od.size() != 4 || od != exp_d || ol[3] !== 1'b1) begin
      failures++;
      $display("FAIL reset_recover: got %0d beats first=%0d, want 4 beats 3,4,1,2",
               od.size(), od.size() > 0 ? od[0] : 8'd0);
    end
  endtask

  initial begin
    test_reset();
    test_write_port();
    test_lengths();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
